// File: rtl/memory_stage_if.sv
// Bundles the EX/MEM handshake, data-cache request and MEM/WB register signals of the memory stage.
// The stage itself uses the slave view; the surrounding pipeline and cache drive the master view.
interface memory_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
);
  // EX/MEM side
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic [WORD_W-1:0] ex_port_o;
  logic [WORD_W-1:0] ex_store_data;
  logic [WORD_W-1:0] ex_NPC;
  logic [WORD_W-1:0] ex_LUI;
  logic [1:0]        ex_MemtoReg;
  logic              ex_RegWrite;
  logic [REG_AW-1:0] ex_wsel;
  logic              ex_halt;

  // Data cache side
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  // MEM/WB register
  logic              wb_valid;
  logic [WORD_W-1:0] wb_port_o;
  logic [WORD_W-1:0] wb_NPC;
  logic [WORD_W-1:0] wb_dmemload;
  logic [WORD_W-1:0] wb_LUI;
  logic [1:0]        wb_MemtoReg;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_wsel;
  logic              wb_halt;

  modport slave (
    input  ex_valid, ex_MemRead, ex_MemWrite, ex_port_o, ex_store_data, ex_NPC,
           ex_LUI, ex_MemtoReg, ex_RegWrite, ex_wsel, ex_halt, dhit, dmemload,
    output ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore,
           wb_valid, wb_port_o, wb_NPC, wb_dmemload, wb_LUI, wb_MemtoReg,
           wb_RegWrite, wb_wsel, wb_halt
  );

  modport master (
    output ex_valid, ex_MemRead, ex_MemWrite, ex_port_o, ex_store_data, ex_NPC,
           ex_LUI, ex_MemtoReg, ex_RegWrite, ex_wsel, ex_halt, dhit, dmemload,
    input  ex_ready, dmemREN, dmemWEN, dmemaddr, dmemstore,
           wb_valid, wb_port_o, wb_NPC, wb_dmemload, wb_LUI, wb_MemtoReg,
           wb_RegWrite, wb_wsel, wb_halt
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: accepts one instruction from EX/MEM, runs its data-cache access until dhit,
// and fills the MEM/WB register consumed by writeback.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic        CLK,
  input  logic        RST,
  memory_stage_if.slave bus,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   is_mem;

  // Fields of a memory instruction parked for the duration of its cache access
  logic [WORD_W-1:0] hold_port_o_p0;
  logic [WORD_W-1:0] hold_npc_p0;
  logic [WORD_W-1:0] hold_lui_p0;
  logic [1:0]        hold_memtoreg_p0;
  logic              hold_regwrite_p0;
  logic [REG_AW-1:0] hold_wsel_p0;
  logic              hold_halt_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

  always_comb begin
    bus.ex_ready = (state == IDLE) && !halted;
    xfer         = bus.ex_valid && bus.ex_ready;
    is_mem       = bus.ex_MemRead || bus.ex_MemWrite;
    state_nxt    = state;
    case (state)
      IDLE:    if (xfer && is_mem) state_nxt = ACCESS;
      ACCESS:  if (bus.dhit)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- stage p0: capture a memory instruction into the hold registers ----
  always_ff @(posedge CLK) begin
    if (state == IDLE && xfer && is_mem) begin
      hold_port_o_p0   <= bus.ex_port_o;
      hold_npc_p0      <= bus.ex_NPC;
      hold_lui_p0      <= bus.ex_LUI;
      hold_memtoreg_p0 <= bus.ex_MemtoReg;
      hold_regwrite_p0 <= bus.ex_RegWrite;
      hold_wsel_p0     <= bus.ex_wsel;
      hold_halt_p0     <= bus.ex_halt;
    end
  end

  // ---- stage p1: cache request and MEM/WB register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.dmemREN     <= 1'b0;
      bus.dmemWEN     <= 1'b0;
      bus.dmemaddr    <= '0;
      bus.dmemstore   <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_port_o   <= '0;
      bus.wb_NPC      <= '0;
      bus.wb_dmemload <= '0;
      bus.wb_LUI      <= '0;
      bus.wb_MemtoReg <= '0;
      bus.wb_RegWrite <= 1'b0;
      bus.wb_wsel     <= '0;
      bus.wb_halt     <= 1'b0;
      halted          <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && is_mem) begin
            bus.dmemaddr  <= word_align(bus.ex_port_o);
            bus.dmemstore <= bus.ex_store_data;
            bus.dmemWEN   <= bus.ex_MemWrite;
            // A write takes priority when both request bits are set
            bus.dmemREN   <= bus.ex_MemRead && !bus.ex_MemWrite;
          end else if (xfer) begin
            bus.wb_valid    <= 1'b1;
            bus.wb_port_o   <= bus.ex_port_o;
            bus.wb_NPC      <= bus.ex_NPC;
            bus.wb_dmemload <= '0;
            bus.wb_LUI      <= bus.ex_LUI;
            bus.wb_MemtoReg <= bus.ex_MemtoReg;
            bus.wb_RegWrite <= bus.ex_RegWrite;
            bus.wb_wsel     <= bus.ex_wsel;
            bus.wb_halt     <= bus.ex_halt;
            if (bus.ex_halt) halted <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus.dhit) begin
            bus.wb_valid    <= 1'b1;
            bus.wb_port_o   <= hold_port_o_p0;
            bus.wb_NPC      <= hold_npc_p0;
            bus.wb_dmemload <= bus.dmemREN ? bus.dmemload : '0;
            bus.wb_LUI      <= hold_lui_p0;
            bus.wb_MemtoReg <= hold_memtoreg_p0;
            bus.wb_RegWrite <= hold_regwrite_p0;
            bus.wb_wsel     <= hold_wsel_p0;
            bus.wb_halt     <= hold_halt_p0;
            bus.dmemREN     <= 1'b0;
            bus.dmemWEN     <= 1'b0;
            if (hold_halt_p0) halted <= 1'b1;
          end else begin
            stall_cycles <= sat_inc(stall_cycles);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
